// File: rtl/vga_fb_reader_if.sv
// Frame-buffer RAM read port and CPU bank-swap handshake for vga_fb_reader.
// The master side is the display reader and the slave side is the RAM/CPU.
interface vga_fb_reader_if #(
  parameter int ADDR_W = 16
);
  logic              mem_rd_en;
  logic [ADDR_W:0]   mem_addr;
  logic [7:0]        mem_rd_data;
  logic              swap_req;
  logic              swap_ack;

  modport master (
    output mem_rd_en, mem_addr, swap_ack,
    input  mem_rd_data, swap_req
  );

  modport slave (
    input  mem_rd_en, mem_addr, swap_ack,
    output mem_rd_data, swap_req
  );
endinterface

// File: rtl/vga_fb_reader.sv
// 640x480@60 VGA timing plus a double-buffered frame-buffer reader with latency-aligned pins.
// Optional macro FB_RGB332_EN: treat RAM bytes as RGB332 instead of grayscale.
module vga_fb_reader #(
  parameter int          ADDR_W   = 16,
  parameter int          IMG_W    = 256,
  parameter int          IMG_H    = 256,
  parameter int          IMG_X0   = 192,
  parameter int          IMG_Y0   = 112,
  parameter int          RD_LAT   = 2,
  parameter logic [23:0] BG_COLOR = 24'h10A6ED
) (
  input  logic                   VGA_CLK_IN,
  input  logic                   rst,
  vga_fb_reader_if.master        fb,
  output logic                   frame_start,
  output logic                   o_hsync,
  output logic                   o_vsync,
  output logic                   VGA_CLK_OUT,
  output logic [7:0]             o_red,
  output logic [7:0]             o_green,
  output logic [7:0]             o_blue
);

  localparam logic [9:0] H_LAST = 10'd799;
  localparam logic [9:0] V_LAST = 10'd524;
  localparam logic [9:0] H_SYNC = 10'd96;
  localparam logic [9:0] V_SYNC = 10'd2;
  localparam logic [9:0] H_VIS0 = 10'd144;
  localparam logic [9:0] H_VIS1 = 10'd783;
  localparam logic [9:0] V_VIS0 = 10'd35;
  localparam logic [9:0] V_VIS1 = 10'd514;
  localparam logic [9:0] WIN_X0 = 10'(144 + IMG_X0);
  localparam logic [9:0] WIN_X1 = 10'(144 + IMG_X0 + IMG_W - 1);
  localparam logic [9:0] WIN_Y0 = 10'(35 + IMG_Y0);
  localparam logic [9:0] WIN_Y1 = 10'(35 + IMG_Y0 + IMG_H - 1);
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(IMG_W * IMG_H - 1);

  generate
    if (IMG_X0 + IMG_W > 640 || IMG_Y0 + IMG_H > 480) begin : g_bad_window
      $error("vga_fb_reader: image window extends past the visible area");
    end
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
      $error("vga_fb_reader: RD_LAT must be 1..4");
    end
    if (IMG_W * IMG_H > 2 ** ADDR_W) begin : g_bad_addr
      $error("vga_fb_reader: image does not fit in one bank");
    end
  endgenerate

  typedef struct packed {
    logic hs;
    logic vs;
    logic vis;
    logic win;
  } flags_t;

  logic [9:0]          cx, cy;
  logic [ADDR_W-1:0]   pix_addr;
  logic                bank;
  logic                at_origin, at_last;
  flags_t              flags;
  flags_t [RD_LAT:0]   pipe;
  logic [23:0]         win_rgb;

  assign VGA_CLK_OUT = VGA_CLK_IN;
  assign at_origin   = (cx == '0) && (cy == '0);
  assign at_last     = (cx == H_LAST) && (cy == V_LAST);
  // Counters sit at (0,0) during reset, so gate the pulse to keep outputs low.
  assign frame_start = at_origin && !rst;

  // NOTE: every field is assigned on every pass, so no latch can be inferred.
  always_comb begin
    flags.hs  = cx < H_SYNC;
    flags.vs  = cy < V_SYNC;
    flags.vis = (cx >= H_VIS0) && (cx <= H_VIS1) && (cy >= V_VIS0) && (cy <= V_VIS1);
    flags.win = flags.vis && (cx >= WIN_X0) && (cx <= WIN_X1)
                && (cy >= WIN_Y0) && (cy <= WIN_Y1);
  end

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge VGA_CLK_IN or posedge rst) begin
    if (rst) begin
      cx <= '0;
      cy <= '0;
    end else if (cx == H_LAST) begin
      cx <= '0;
      cy <= (cy == V_LAST) ? '0 : cy + 1'b1;
    end else begin
      cx <= cx + 1'b1;
    end
  end

  // Bank toggles on the edge into (0,0); earlier reads already carry the old bank.
  always_ff @(posedge VGA_CLK_IN or posedge rst) begin
    if (rst) begin
      pix_addr     <= '0;
      bank         <= 1'b0;
      fb.mem_rd_en <= 1'b0;
      fb.mem_addr  <= '0;
      fb.swap_ack  <= 1'b0;
    end else begin
      fb.mem_rd_en <= flags.win;
      fb.mem_addr  <= {bank, pix_addr};
      fb.swap_ack  <= at_last && fb.swap_req;
      if (at_last && fb.swap_req) bank <= ~bank;
      if (at_origin) pix_addr <= '0;
      else if (flags.win && pix_addr != LAST_PIX) pix_addr <= pix_addr + 1'b1;
    end
  end

  // NOTE: the flag delay line is small and visible at the pins, so it is reset too.
  always_ff @(posedge VGA_CLK_IN or posedge rst) begin
    if (rst) pipe <= '0;
    else     pipe <= {pipe[RD_LAT-1:0], flags};
  end

`ifdef FB_RGB332_EN
  assign win_rgb = {fb.mem_rd_data[7:5], fb.mem_rd_data[7:5], fb.mem_rd_data[7:6],
                    fb.mem_rd_data[4:2], fb.mem_rd_data[4:2], fb.mem_rd_data[4:3],
                    {4{fb.mem_rd_data[1:0]}}};
`else
  assign win_rgb = {3{fb.mem_rd_data}};
`endif

  always_ff @(posedge VGA_CLK_IN or posedge rst) begin
    if (rst) begin
      o_hsync <= 1'b0;
      o_vsync <= 1'b0;
      {o_red, o_green, o_blue} <= '0;
    end else begin
      o_hsync <= pipe[RD_LAT].hs;
      o_vsync <= pipe[RD_LAT].vs;
      if (pipe[RD_LAT].win)      {o_red, o_green, o_blue} <= win_rgb;
      else if (pipe[RD_LAT].vis) {o_red, o_green, o_blue} <= BG_COLOR;
      else                       {o_red, o_green, o_blue} <= '0;
    end
  end

endmodule

// File: tb/tb_vga_fb_reader.sv
// Directed bench for vga_fb_reader: timing table, window fetch, bank swap and async reset.
// Counters are jumped with force/release so each corner is reached in a few cycles.
module tb_vga_fb_reader;
  localparam int ADDR_W = 16;
  localparam int RD_LAT = 2;
  localparam logic [23:0] BG = 24'h10A6ED;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_start, o_hsync, o_vsync, clk_out;
  logic [7:0] o_red, o_green, o_blue;

  vga_fb_reader_if #(.ADDR_W(ADDR_W)) fb ();

  vga_fb_reader #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .VGA_CLK_IN (clk),
    .rst        (rst),
    .fb         (fb),
    .frame_start(frame_start),
    .o_hsync    (o_hsync),
    .o_vsync    (o_vsync),
    .VGA_CLK_OUT(clk_out),
    .o_red      (o_red),
    .o_green    (o_green),
    .o_blue     (o_blue)
  );

  always #5 clk = ~clk;

  // RAM model: data follows mem_rd_en by RD_LAT cycles.
  logic [7:0] ram_pipe [RD_LAT];
  always @(posedge clk) begin
`ifdef FB_RGB332_EN
    ram_pipe[0] <= fb.mem_rd_en ? 8'hE3 : 8'h00;
`else
    ram_pipe[0] <= fb.mem_rd_en ? fb.mem_addr[7:0] : 8'h00;
`endif
    for (int i = 1; i < RD_LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
  end
  assign fb.mem_rd_data = ram_pipe[RD_LAT-1];

  function automatic logic [23:0] pix_rgb(input logic [7:0] a);
`ifdef FB_RGB332_EN
    return 24'hFF00FF;
`else
    return {a, a, a};
`endif
  endfunction

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [9:0]  jx, jy;
  logic [15:0] jp;

  task jump(input logic [9:0] x, input logic [9:0] y);
    @(negedge clk);
    jx = x;
    jy = y;
    force dut.cx = jx;
    force dut.cy = jy;
    #1;
    release dut.cx;
    release dut.cy;
  endtask

  task jump_pix(input logic [9:0] x, input logic [9:0] y, input logic [15:0] p);
    @(negedge clk);
    jx = x;
    jy = y;
    jp = p;
    force dut.cx = jx;
    force dut.cy = jy;
    force dut.pix_addr = jp;
    #1;
    release dut.cx;
    release dut.cy;
    release dut.pix_addr;
  endtask

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        hs;
    logic        vs;
    logic        en;
    logic        chk_rgb;
    logic [23:0] rgb;
  } vec_t;

  vec_t vt [19];

  int  hs_hi, vs_hi, rises, first_rise, prev_rise, last_rise, nz, fs_cnt;
  int  ack_cnt, bad, good, n;
  logic prev_hs, fs_seen, coincide;

  initial begin
    vt[0]  = '{10'd0,   10'd0,   1'b1, 1'b1, 1'b0, 1'b1, 24'h0};
    vt[1]  = '{10'd95,  10'd1,   1'b1, 1'b1, 1'b0, 1'b1, 24'h0};
    vt[2]  = '{10'd96,  10'd1,   1'b0, 1'b1, 1'b0, 1'b1, 24'h0};
    vt[3]  = '{10'd799, 10'd1,   1'b0, 1'b1, 1'b0, 1'b1, 24'h0};
    vt[4]  = '{10'd0,   10'd2,   1'b1, 1'b0, 1'b0, 1'b1, 24'h0};
    vt[5]  = '{10'd143, 10'd100, 1'b0, 1'b0, 1'b0, 1'b1, 24'h0};
    vt[6]  = '{10'd144, 10'd100, 1'b0, 1'b0, 1'b0, 1'b1, BG};
    vt[7]  = '{10'd783, 10'd514, 1'b0, 1'b0, 1'b0, 1'b1, BG};
    vt[8]  = '{10'd784, 10'd200, 1'b0, 1'b0, 1'b0, 1'b1, 24'h0};
    vt[9]  = '{10'd400, 10'd34,  1'b0, 1'b0, 1'b0, 1'b1, 24'h0};
    vt[10] = '{10'd400, 10'd35,  1'b0, 1'b0, 1'b0, 1'b1, BG};
    vt[11] = '{10'd400, 10'd515, 1'b0, 1'b0, 1'b0, 1'b1, 24'h0};
    vt[12] = '{10'd335, 10'd147, 1'b0, 1'b0, 1'b0, 1'b1, BG};
    vt[13] = '{10'd592, 10'd147, 1'b0, 1'b0, 1'b0, 1'b1, BG};
    vt[14] = '{10'd400, 10'd403, 1'b0, 1'b0, 1'b0, 1'b1, BG};
    vt[15] = '{10'd400, 10'd146, 1'b0, 1'b0, 1'b0, 1'b1, BG};
    vt[16] = '{10'd335, 10'd300, 1'b0, 1'b0, 1'b0, 1'b1, BG};
    vt[17] = '{10'd336, 10'd147, 1'b0, 1'b0, 1'b1, 1'b0, 24'h0};
    vt[18] = '{10'd591, 10'd402, 1'b0, 1'b0, 1'b1, 1'b0, 24'h0};

    fb.swap_req = 1'b0;
    #1 rst = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_rgb", 32'({o_red, o_green, o_blue}), 32'h0);
    check("rst_ctrl", 32'({o_hsync, o_vsync, frame_start, fb.mem_rd_en, fb.swap_ack}), 32'h0);
    check("rst_addr", 32'(fb.mem_addr), 32'h0);
    check("clk_out_lo", 32'(clk_out), 32'h0);
    @(posedge clk);
    #1 check("clk_out_hi", 32'(clk_out), 32'h1);

    @(negedge clk);
    rst = 1'b0;
    #1 check("fs_after_release", 32'(frame_start), 32'h1);

    // First 2000 cycles: sync widths, line period, blanking, latency
    hs_hi = 0; vs_hi = 0; rises = 0; first_rise = 0; prev_rise = 0; last_rise = 0;
    nz = 0; fs_cnt = 0; prev_hs = 1'b0;
    for (int i = 1; i <= 2000; i++) begin
      @(negedge clk);
      if (o_hsync) hs_hi++;
      if (o_vsync) vs_hi++;
      if (o_hsync && !prev_hs) begin
        rises++;
        if (rises == 1) first_rise = i;
        prev_rise = last_rise;
        last_rise = i;
      end
      prev_hs = o_hsync;
      if ({o_red, o_green, o_blue} != 24'h0) nz++;
      if (frame_start) fs_cnt++;
    end
    check("hs_high_cycles", 32'(hs_hi), 32'd288);
    check("vs_high_cycles", 32'(vs_hi), 32'd1600);
    check("hs_rises", 32'(rises), 32'd3);
    check("hs_first_rise", 32'(first_rise), 32'd4);
    check("line_period", 32'(last_rise - prev_rise), 32'd800);
    check("blank_rgb", 32'(nz), 32'd0);
    check("fs_none_early", 32'(fs_cnt), 32'd0);

    // Frame wrap: (790,524) reaches (0,0) after 10 cycles
    jump(10'd790, 10'd524);
    n = 0; fs_seen = 1'b0;
    while (!fs_seen && n < 50) begin
      @(negedge clk);
      n++;
      if (frame_start) fs_seen = 1'b1;
    end
    check("frame_wrap_cycles", 32'(n), 32'd10);

    // Timing/colour table
    foreach (vt[k]) begin
      jump(vt[k].x, vt[k].y);
      @(negedge clk);
      check($sformatf("tbl%0d_rd_en", k), 32'(fb.mem_rd_en), 32'(vt[k].en));
      repeat (3) @(negedge clk);
      check($sformatf("tbl%0d_sync", k), 32'({o_hsync, o_vsync}), 32'({vt[k].hs, vt[k].vs}));
      if (vt[k].chk_rgb)
        check($sformatf("tbl%0d_rgb", k), 32'({o_red, o_green, o_blue}), 32'(vt[k].rgb));
    end

    // First window line: address 0 at (336,147), pixels 0,1,2 ... 255 then background
    jump(10'd0, 10'd0);
    jump(10'd330, 10'd147);
    for (int i = 1; i <= 266; i++) begin
      @(negedge clk);
      if (i == 6)   check("win_pre_rd_en", 32'(fb.mem_rd_en), 32'h0);
      if (i == 7)   check("win_first_addr", 32'({fb.mem_rd_en, fb.mem_addr}), 32'({1'b1, 17'd0}));
      if (i == 8)   check("win_second_addr", 32'(fb.mem_addr), 32'd1);
      if (i == 9)   check("win_pre_rgb", 32'({o_red, o_green, o_blue}), 32'(BG));
      if (i == 10)  check("win_px0_rgb", 32'({o_red, o_green, o_blue}), 32'(pix_rgb(8'h00)));
      if (i == 11)  check("win_px1_rgb", 32'({o_red, o_green, o_blue}), 32'(pix_rgb(8'h01)));
      if (i == 12)  check("win_px2_rgb", 32'({o_red, o_green, o_blue}), 32'(pix_rgb(8'h02)));
      if (i == 265) check("win_px255_rgb", 32'({o_red, o_green, o_blue}), 32'(pix_rgb(8'hFF)));
      if (i == 266) check("win_post_rgb", 32'({o_red, o_green, o_blue}), 32'(BG));
    end

    // Last window line: final address 65535, then the address holds
    jump_pix(10'd330, 10'd402, 16'hFF00);
    for (int i = 1; i <= 265; i++) begin
      @(negedge clk);
      if (i == 262) check("last_addr", 32'({fb.mem_rd_en, fb.mem_addr}), 32'({1'b1, 1'b0, 16'hFFFF}));
      if (i == 263) check("last_post_rd_en", 32'(fb.mem_rd_en), 32'h0);
      if (i == 265) check("last_px_rgb", 32'({o_red, o_green, o_blue}), 32'(pix_rgb(8'hFF)));
    end
    jump(10'd330, 10'd402);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 8) check("last_addr_hold", 32'({fb.mem_rd_en, fb.mem_addr}), 32'({1'b1, 1'b0, 16'hFFFF}));
    end

    // Swap request mid-frame, held until ack
    ack_cnt = 0;
    jump(10'd0, 10'd200);
    fb.swap_req = 1'b1;
    jump(10'd330, 10'd300);
    bad = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (fb.mem_rd_en && fb.mem_addr[16]) bad++;
      if (fb.swap_ack) ack_cnt++;
    end
    check("swap_old_bank_reads", 32'(bad), 32'd0);
    jump(10'd790, 10'd524);
    n = 0; fs_seen = 1'b0; coincide = 1'b0;
    while (!fs_seen && n < 50) begin
      @(negedge clk);
      n++;
      if (fb.swap_ack) ack_cnt++;
      if (frame_start) begin
        fs_seen = 1'b1;
        coincide = fb.swap_ack;
      end
    end
    fb.swap_req = 1'b0;
    check("swap_fs_wait", 32'(n), 32'd10);
    check("swap_ack_with_fs", 32'(coincide), 32'h1);
    repeat (3) begin
      @(negedge clk);
      if (fb.swap_ack) ack_cnt++;
    end
    check("swap_ack_once", 32'(ack_cnt), 32'd1);
    jump(10'd330, 10'd147);
    good = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (fb.mem_rd_en && fb.mem_addr[16]) good++;
    end
    check("swap_new_bank_reads", 32'(good), 32'd14);

    // Request dropped before the (799,524) sample point has no effect
    jump(10'd795, 10'd524);
    fb.swap_req = 1'b1;
    repeat (4) @(negedge clk);
    fb.swap_req = 1'b0;
    @(negedge clk);
    check("late_drop_fs", 32'(frame_start), 32'h1);
    check("late_drop_no_ack", 32'(fb.swap_ack), 32'h0);
    jump(10'd330, 10'd147);
    good = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (fb.mem_rd_en && fb.mem_addr[16]) good++;
    end
    check("late_drop_bank_kept", 32'(good), 32'd14);

    // Asynchronous reset mid-line
    jump_pix(10'd500, 10'd300, 16'h1234);
    repeat (4) @(negedge clk);
    check("pre_rst_rgb", 32'({o_red, o_green, o_blue}), 32'(pix_rgb(8'h34)));
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_rgb", 32'({o_red, o_green, o_blue}), 32'h0);
    check("async_rst_ctrl", 32'({o_hsync, o_vsync, frame_start, fb.mem_rd_en, fb.swap_ack}), 32'h0);
    check("async_rst_addr", 32'(fb.mem_addr), 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 check("fs_after_rst2", 32'(frame_start), 32'h1);
    hs_hi = 0; first_rise = 0; prev_hs = 1'b0;
    for (int i = 1; i <= 110; i++) begin
      @(negedge clk);
      if (o_hsync) hs_hi++;
      if (o_hsync && !prev_hs && first_rise == 0) first_rise = i;
      prev_hs = o_hsync;
    end
    check("rst2_hs_high", 32'(hs_hi), 32'd96);
    check("rst2_hs_rise", 32'(first_rise), 32'd4);
    jump(10'd330, 10'd147);
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      if (i == 7) check("rst2_bank0_addr", 32'({fb.mem_rd_en, fb.mem_addr}), 32'({1'b1, 17'd0}));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
